// File: rtl/arch_defs_pkg.sv
// Shared definitions for the SAP-2 fetch unit: state encoding and the reset vector default.
package arch_defs_pkg;

  typedef enum logic [2:0] {
    S_RESET_VECTOR = 3'd0,
    S_LATCH_ADDR   = 3'd1,
    S_READ_BYTE    = 3'd2,
    S_LATCH_BYTE   = 3'd3,
    S_CHECK_MORE   = 3'd4,
    S_PRESENT      = 3'd5,
    S_HALT         = 3'd6
  } fetch_state_t;

  localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'hF000;

endpackage

// File: rtl/fetch_operand_buffer.sv
// Indexed byte-capture register: index 0 holds the opcode, index k holds operand k-1.
module fetch_operand_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_OPERANDS = 3,
  parameter int IDX_W        = $clog2(MAX_OPERANDS + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clr,
  input  logic                             wr_en,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic [DATA_WIDTH-1:0]            opcode,
  output logic [MAX_OPERANDS*DATA_WIDTH-1:0] operands
);

  logic [DATA_WIDTH-1:0]              opcode_q, opcode_d;
  logic [MAX_OPERANDS*DATA_WIDTH-1:0] operands_q, operands_d;

  always_comb begin
    opcode_d   = opcode_q;
    operands_d = operands_q;
    // Clear only the operand slots; the opcode is always rewritten by the first byte.
    if (clr) operands_d = '0;
    if (wr_en) begin
      if (wr_idx == '0) opcode_d = wr_data;
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        if (wr_idx == IDX_W'(i + 1)) operands_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      opcode_q   <= '0;
      operands_q <= '0;
    end else begin
      opcode_q   <= opcode_d;
      operands_q <= operands_d;
    end
  end

  assign opcode   = opcode_q;
  assign operands = operands_q;

endmodule

// File: rtl/multi_byte_fetch_unit.sv
// SAP-2 multi-byte instruction fetch sequencer with valid/ready hand-off to execute.
// Optional feature macro: FETCH_BRANCH_EN (honour branch_valid/branch_target on handshake).
module multi_byte_fetch_unit
  import arch_defs_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    MAX_OPERANDS = 3,
  parameter int                    MEM_LATENCY  = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEFAULT)
) (
  input  logic                               clk,
  input  logic                               reset,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic                               mem_read,
  input  logic [DATA_WIDTH-1:0]              mem_data,
  output logic [DATA_WIDTH-1:0]              len_opcode,
  input  logic [$clog2(MAX_OPERANDS+1)-1:0]  len_operands,
  output logic                               instr_valid,
  input  logic                               instr_ready,
  output logic [DATA_WIDTH-1:0]              instr_opcode,
  output logic [MAX_OPERANDS*DATA_WIDTH-1:0] instr_operands,
  output logic [ADDR_WIDTH-1:0]              instr_pc,
  output logic [ADDR_WIDTH-1:0]              pc_out,
  input  logic                               halt,
  input  logic                               branch_valid,
  input  logic [ADDR_WIDTH-1:0]              branch_target,
  output logic                               halted,
  output logic                               len_error
);

  localparam int LEN_W  = $clog2(MAX_OPERANDS + 1);
  localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  fetch_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_read_q, mem_read_d;
  logic [LEN_W-1:0]        idx_q, idx_d;
  logic [LEN_W-1:0]        eff_len_q, eff_len_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    len_error_q, len_error_d;
  logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
  logic [LEN_W-1:0]        len_eff;
  logic [DATA_WIDTH-1:0]   opcode_w;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] n);
    if (n > LEN_W'(MAX_OPERANDS)) return LEN_W'(MAX_OPERANDS);
    return n;
  endfunction

`ifndef FETCH_BRANCH_EN
  logic unused_branch;
  assign unused_branch = ^{branch_valid, branch_target};
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    mem_read_d  = 1'b0;
    idx_d       = idx_q;
    eff_len_d   = eff_len_q;
    wait_d      = wait_q;
    len_error_d = len_error_q;
    instr_pc_d  = instr_pc_q;
    len_eff     = eff_len_q;
    case (state_q)
      S_RESET_VECTOR: begin
        pc_d    = RESET_VECTOR;
        idx_d   = '0;
        state_d = S_LATCH_ADDR;
      end
      S_LATCH_ADDR: begin
        mem_addr_d = pc_q;
        mem_read_d = 1'b1;
        wait_d     = WAIT_W'(MEM_LATENCY - 1);
        state_d    = S_READ_BYTE;
      end
      S_READ_BYTE: begin
        if (wait_q == '0) begin
          state_d = S_LATCH_BYTE;
        end else begin
          wait_d     = wait_q - WAIT_W'(1);
          mem_read_d = 1'b1;
        end
      end
      S_LATCH_BYTE: begin
        pc_d = pc_q + ADDR_WIDTH'(1);
        if (idx_q == '0) instr_pc_d = pc_q;
        state_d = S_CHECK_MORE;
      end
      S_CHECK_MORE: begin
        // The decoder sees the freshly latched opcode here, so length is sampled once per instruction.
        if (idx_q == '0) begin
          len_eff   = clamp_len(len_operands);
          eff_len_d = len_eff;
          if (len_operands > LEN_W'(MAX_OPERANDS)) len_error_d = 1'b1;
        end
        if (idx_q < len_eff) begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = S_LATCH_ADDR;
        end else begin
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (instr_ready) begin
          idx_d = '0;
          if (halt) begin
            state_d = S_HALT;
          end else begin
            state_d = S_LATCH_ADDR;
`ifdef FETCH_BRANCH_EN
            if (branch_valid) pc_d = branch_target;
`endif
          end
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RESET_VECTOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_RESET_VECTOR;
      pc_q        <= '0;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      idx_q       <= '0;
      eff_len_q   <= '0;
      wait_q      <= '0;
      len_error_q <= 1'b0;
      instr_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_read_q  <= mem_read_d;
      idx_q       <= idx_d;
      eff_len_q   <= eff_len_d;
      wait_q      <= wait_d;
      len_error_q <= len_error_d;
      instr_pc_q  <= instr_pc_d;
    end
  end

  fetch_operand_buffer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MAX_OPERANDS(MAX_OPERANDS),
    .IDX_W       (LEN_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     ((state_q == S_LATCH_ADDR) && (idx_q == '0)),
    .wr_en   (state_q == S_LATCH_BYTE),
    .wr_idx  (idx_q),
    .wr_data (mem_data),
    .opcode  (opcode_w),
    .operands(instr_operands)
  );

  assign mem_addr     = mem_addr_q;
  assign mem_read     = mem_read_q;
  assign len_opcode   = opcode_w;
  assign instr_opcode = opcode_w;
  assign instr_pc     = instr_pc_q;
  assign pc_out       = pc_q;
  assign instr_valid  = (state_q == S_PRESENT);
  assign halted       = (state_q == S_HALT);
  assign len_error    = len_error_q;

endmodule
